// File: rtl/csi2_packet_parser.sv
// Single-lane CSI-2 packet parser: header decode, ECC check, payload gating,
// payload CRC check and frame/line sync pulses for one packet per HS burst.
module csi2_packet_parser #(
   parameter logic [15:0] WC_MAX = 16'd4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs_mode,
   input  logic        found_sot,
   input  logic        byte_gate,
   input  logic [7:0]  mipi_byte,
   output logic        hdr_valid,
   output logic [1:0]  vc,
   output logic [5:0]  dt,
   output logic [15:0] wc,
   output logic        ecc_err,
   output logic        pix_valid,
   output logic [7:0]  pix_byte,
   output logic        pkt_end,
   output logic        crc_err,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic        trunc_err,
   output logic        wc_err
);

   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, WAIT_LP} state_t;

   state_t      state, state_n;
   logic        acc;
   logic [1:0]  hdr_cnt;
   logic [7:0]  di, hb1, hb2, crc_lo;
   logic        crc_cnt;
   logic [15:0] remain, crc, wc_rx;
   logic [5:0]  dt_rx;
   logic        short_pkt, ecc_bad;
   logic        hdr_fire, pix_fire, end_fire, trunc_fire, wc_fire;

   // Row masks of the 6-bit header Hamming code over D[23:0].
   function automatic logic [7:0] ecc_calc(input logic [23:0] d);
      logic [7:0] p;
      p    = 8'h00;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] c,
                                            input logic [7:0]  d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
      return r;
   endfunction

   assign acc       = hs_mode & found_sot & byte_gate;
   assign wc_rx     = {hb2, hb1};
   assign dt_rx     = di[5:0];
   assign short_pkt = (dt_rx[5:4] == 2'b00);
   assign ecc_bad   = (mipi_byte != ecc_calc({hb2, hb1, di}));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      hdr_fire   = 1'b0;
      pix_fire   = 1'b0;
      end_fire   = 1'b0;
      trunc_fire = 1'b0;
      wc_fire    = 1'b0;
      unique case (state)
         IDLE: if (acc) state_n = HDR;
         HDR: begin
            if (!hs_mode) begin
               trunc_fire = 1'b1;
               state_n    = IDLE;
            end else if (acc && hdr_cnt == 2'd3) begin
               hdr_fire = 1'b1;
               if (short_pkt) begin
                  state_n = WAIT_LP;
               end else if (wc_rx > WC_MAX) begin
                  wc_fire = 1'b1;
                  state_n = WAIT_LP;
               end else if (wc_rx == 16'd0) begin
                  state_n = CRC;
               end else begin
                  state_n = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (!hs_mode) begin
               trunc_fire = 1'b1;
               state_n    = IDLE;
            end else if (acc) begin
               pix_fire = 1'b1;
               if (remain == 16'd1) state_n = CRC;
            end
         end
         CRC: begin
            if (!hs_mode) begin
               trunc_fire = 1'b1;
               state_n    = IDLE;
            end else if (acc && crc_cnt) begin
               end_fire = 1'b1;
               state_n  = WAIT_LP;
            end
         end
         WAIT_LP: if (!hs_mode) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_cnt     <= 2'd0;
         di          <= 8'h00;
         hb1         <= 8'h00;
         hb2         <= 8'h00;
         crc_lo      <= 8'h00;
         crc_cnt     <= 1'b0;
         remain      <= 16'd0;
         crc         <= 16'hFFFF;
         hdr_valid   <= 1'b0;
         vc          <= 2'd0;
         dt          <= 6'd0;
         wc          <= 16'd0;
         ecc_err     <= 1'b0;
         pix_valid   <= 1'b0;
         pix_byte    <= 8'h00;
         pkt_end     <= 1'b0;
         crc_err     <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         line_start  <= 1'b0;
         line_end    <= 1'b0;
         trunc_err   <= 1'b0;
         wc_err      <= 1'b0;
      end else begin
         hdr_valid   <= hdr_fire;
         pix_valid   <= pix_fire;
         pkt_end     <= end_fire;
         trunc_err   <= trunc_fire;
         wc_err      <= wc_fire;
         frame_start <= hdr_fire & short_pkt & ~ecc_bad & (dt_rx == 6'h00);
         frame_end   <= hdr_fire & short_pkt & ~ecc_bad & (dt_rx == 6'h01);
         line_start  <= hdr_fire & short_pkt & ~ecc_bad & (dt_rx == 6'h02);
         line_end    <= hdr_fire & short_pkt & ~ecc_bad & (dt_rx == 6'h03);
         if (state == IDLE && acc) begin
            di      <= mipi_byte;
            hdr_cnt <= 2'd1;
         end
         if (state == HDR && acc) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd1) hb1 <= mipi_byte;
            if (hdr_cnt == 2'd2) hb2 <= mipi_byte;
         end
         // CRC seed reloads per header so an aborted packet leaves no residue.
         if (hdr_fire) begin
            vc      <= di[7:6];
            dt      <= dt_rx;
            wc      <= wc_rx;
            ecc_err <= ecc_bad;
            remain  <= wc_rx;
            crc     <= 16'hFFFF;
            crc_cnt <= 1'b0;
         end
         if (pix_fire) begin
            pix_byte <= mipi_byte;
            crc      <= crc_step(crc, mipi_byte);
            remain   <= remain - 16'd1;
         end
         if (state == CRC && acc && !crc_cnt) begin
            crc_lo  <= mipi_byte;
            crc_cnt <= 1'b1;
         end
         if (end_fire) crc_err <= (crc != {mipi_byte, crc_lo});
      end
   end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser: table of short-packet headers
// followed by hand-written long-packet, truncation, WC-limit and reset cases.
module tb_csi2_packet_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hs_mode = 1'b0;
   logic        found_sot = 1'b0;
   logic        byte_gate = 1'b0;
   logic [7:0]  mipi_byte = 8'h00;
   logic        hdr_valid, ecc_err, pix_valid, pkt_end, crc_err;
   logic [1:0]  vc;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic [7:0]  pix_byte;
   logic        frame_start, frame_end, line_start, line_end;
   logic        trunc_err, wc_err;

   csi2_packet_parser dut (
      .clk(clk), .rst(rst), .hs_mode(hs_mode), .found_sot(found_sot),
      .byte_gate(byte_gate), .mipi_byte(mipi_byte),
      .hdr_valid(hdr_valid), .vc(vc), .dt(dt), .wc(wc), .ecc_err(ecc_err),
      .pix_valid(pix_valid), .pix_byte(pix_byte), .pkt_end(pkt_end),
      .crc_err(crc_err), .frame_start(frame_start), .frame_end(frame_end),
      .line_start(line_start), .line_end(line_end),
      .trunc_err(trunc_err), .wc_err(wc_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int n_hdr = 0, n_pix = 0, n_end = 0, n_trunc = 0;
   int n_wcerr = 0, n_sync = 0, n_b2b = 0;
   logic        pix_prev = 1'b0;
   logic [1:0]  h_vc = '0;
   logic [5:0]  h_dt = '0;
   logic [15:0] h_wc = '0;
   logic        h_ee = 1'b0;
   logic [3:0]  h_sync = '0;
   logic        e_crc = 1'b0;
   logic [7:0]  pix_q[$];

   always @(negedge clk) begin
      if (hdr_valid) begin
         n_hdr++;
         h_vc = vc; h_dt = dt; h_wc = wc; h_ee = ecc_err;
         h_sync = {frame_start, frame_end, line_start, line_end};
      end
      if (frame_start | frame_end | line_start | line_end) n_sync++;
      if (pix_valid) begin
         n_pix++;
         pix_q.push_back(pix_byte);
         if (pix_prev) n_b2b++;
      end
      pix_prev = pix_valid;
      if (pkt_end) begin
         n_end++;
         e_crc = crc_err;
      end
      if (trunc_err) n_trunc++;
      if (wc_err) n_wcerr++;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Syndrome column of each data bit; ECC is the XOR of set-bit columns.
   function automatic logic [7:0] ecc_model(input logic [23:0] d);
      logic [5:0] col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15,
                               6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
                               6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32,
                               6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
      logic [5:0] e = '0;
      for (int i = 0; i < 24; i++) if (d[i]) e ^= col[i];
      return {2'b00, e};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      byte_gate = 1'b1;
      mipi_byte = b;
      tick(1);
      byte_gate = 1'b0;
      tick(3);
   endtask

   task automatic burst_on();
      hs_mode = 1'b1;
      found_sot = 1'b1;
      tick(2);
   endtask

   task automatic burst_off();
      put(8'h5A);
      tick(2);
      hs_mode = 1'b0;
      found_sot = 1'b0;
      tick(3);
   endtask

   task automatic send_hdr(input logic [7:0] di, input logic [15:0] w);
      put(di);
      put(w[7:0]);
      put(w[15:8]);
      put(ecc_model({w, di}));
   endtask

   logic [7:0] pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC,
                            8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                            8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8,
                            8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

   task automatic run_long(input logic [7:0] clo, input logic [7:0] chi,
                           input logic exp_err);
      int s_hdr, s_pix, s_end, base;
      s_hdr = n_hdr; s_pix = n_pix; s_end = n_end; base = pix_q.size();
      burst_on();
      send_hdr(8'h2A, 16'd24);
      for (int i = 0; i < 24; i++) put(pay[i]);
      put(clo);
      put(chi);
      burst_off();
      check("long_hdr_cnt", 64'(n_hdr - s_hdr), 1);
      check("long_dt", h_dt, 6'h2A);
      check("long_wc", h_wc, 16'd24);
      check("long_ecc_err", h_ee, 0);
      check("long_pix_cnt", 64'(n_pix - s_pix), 24);
      for (int i = 0; i < 24; i++)
         if (base + i < pix_q.size())
            check($sformatf("long_pix_byte%0d", i), pix_q[base + i], pay[i]);
      check("long_end_cnt", 64'(n_end - s_end), 1);
      check("long_crc_err", e_crc, exp_err);
   endtask

   typedef struct packed {
      logic [31:0] bytes;
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc;
      logic        ee;
      logic [3:0]  sync;
   } vec_t;

   vec_t vt [7];

   initial begin
      int s_hdr, s_pix, s_end, s_sync, s_trunc, s_wc;
      logic [31:0] bw;

      vt[0] = '{32'h00000000, 2'd0, 6'h00, 16'h0000, 1'b0, 4'b1000};
      vt[1] = '{32'h00000001, 2'd0, 6'h00, 16'h0000, 1'b1, 4'b0000};
      vt[2] = '{32'h00000080, 2'd0, 6'h00, 16'h0000, 1'b1, 4'b0000};
      vt[3] = '{32'h01000007, 2'd0, 6'h01, 16'h0000, 1'b0, 4'b0100};
      vt[4] = '{32'h42010007, 2'd1, 6'h02, 16'h0001, 1'b0, 4'b0010};
      vt[5] = '{32'hC3341202, 2'd3, 6'h03, 16'h1234, 1'b0, 4'b0001};
      vt[6] = '{32'h0800000E, 2'd0, 6'h08, 16'h0000, 1'b0, 4'b0000};

      tick(3);
      check("reset_outputs",
            {hdr_valid, vc, dt, wc, ecc_err, pix_valid, pix_byte, pkt_end,
             crc_err, frame_start, frame_end, line_start, line_end,
             trunc_err, wc_err}, 0);
      rst = 1'b0;
      tick(2);

      for (int r = 0; r < 7; r++) begin
         s_hdr = n_hdr; s_pix = n_pix; s_end = n_end; s_sync = n_sync;
         bw = vt[r].bytes;
         burst_on();
         put(bw[31:24]);
         put(bw[23:16]);
         put(bw[15:8]);
         put(bw[7:0]);
         burst_off();
         check($sformatf("v%0d_hdr_cnt", r), 64'(n_hdr - s_hdr), 1);
         check($sformatf("v%0d_vc", r), h_vc, vt[r].vc);
         check($sformatf("v%0d_dt", r), h_dt, vt[r].dt);
         check($sformatf("v%0d_wc", r), h_wc, vt[r].wc);
         check($sformatf("v%0d_ecc_err", r), h_ee, vt[r].ee);
         check($sformatf("v%0d_sync", r), h_sync, vt[r].sync);
         check($sformatf("v%0d_sync_cnt", r), 64'(n_sync - s_sync),
               64'(vt[r].sync != 4'b0000));
         check($sformatf("v%0d_no_pix", r), 64'(n_pix - s_pix), 0);
         check($sformatf("v%0d_no_end", r), 64'(n_end - s_end), 0);
      end

      run_long(8'hF0, 8'h00, 1'b0);
      run_long(8'hF1, 8'h00, 1'b1);

      s_trunc = n_trunc; s_end = n_end; s_pix = n_pix;
      burst_on();
      send_hdr(8'h2A, 16'd100);
      for (int i = 0; i < 10; i++) put(pay[i]);
      hs_mode = 1'b0;
      tick(3);
      found_sot = 1'b0;
      tick(2);
      check("trunc_cnt", 64'(n_trunc - s_trunc), 1);
      check("trunc_no_end", 64'(n_end - s_end), 0);
      check("trunc_pix_cnt", 64'(n_pix - s_pix), 10);
      check("trunc_held_wc", wc, 16'd100);

      s_hdr = n_hdr; s_end = n_end; s_pix = n_pix; s_trunc = n_trunc;
      burst_on();
      send_hdr(8'h2A, 16'd0);
      put(8'hFF);
      put(8'hFF);
      burst_off();
      check("wc0_hdr_cnt", 64'(n_hdr - s_hdr), 1);
      check("wc0_wc", h_wc, 0);
      check("wc0_end_cnt", 64'(n_end - s_end), 1);
      check("wc0_crc_err", e_crc, 0);
      check("wc0_no_pix", 64'(n_pix - s_pix), 0);
      check("wc0_no_trunc", 64'(n_trunc - s_trunc), 0);

      s_wc = n_wcerr; s_pix = n_pix; s_end = n_end;
      burst_on();
      send_hdr(8'h2A, 16'd4097);
      for (int i = 0; i < 4; i++) put(pay[i]);
      burst_off();
      check("wcmax_err_cnt", 64'(n_wcerr - s_wc), 1);
      check("wcmax_wc", h_wc, 16'd4097);
      check("wcmax_no_pix", 64'(n_pix - s_pix), 0);
      check("wcmax_no_end", 64'(n_end - s_end), 0);

      burst_on();
      send_hdr(8'h6A, 16'd24);
      for (int i = 0; i < 3; i++) put(pay[i + 3]);
      check("pre_rst_dt", dt, 6'h2A);
      check("pre_rst_vc", vc, 2'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_outputs",
            {hdr_valid, vc, dt, wc, ecc_err, pix_valid, pix_byte, pkt_end,
             crc_err, frame_start, frame_end, line_start, line_end,
             trunc_err, wc_err}, 0);
      hs_mode = 1'b0;
      found_sot = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);
      run_long(8'hF0, 8'h00, 1'b0);

      check("pix_spacing", n_b2b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Single-lane MIPI CSI-2 low-level packet parser. It sits directly downstream of the lane byte aligner. It consumes the aligned HS byte stream (byte strobe, byte, SoT-found flag and HS-mode flag) and splits each HS burst into one short or long packet. It outputs the decoded header, header-ECC status, a gated payload byte stream, the payload CRC result and frame/line sync pulses for the pixel unpacker.

## Interface
Parameters:
- WC_MAX, default 16'd4096: largest accepted long-packet word count. Larger WC flags `wc_err` and the burst is discarded.

Ports:
- clk  in  1  byte-domain clock, same clock as the aligner.
- rst  in  1  asynchronous, active-high reset.
- hs_mode  in  1  aligner HS-mode level.
- found_sot  in  1  aligner sync-byte-locked level.
- byte_gate  in  1  one-clock strobe; at most one per 4 clocks.
- mipi_byte  in  8  aligned byte, valid when byte_gate=1.
- hdr_valid  out  1  one-clock pulse; vc/dt/wc/ecc_err are valid.
- vc  out  2  virtual channel, DI[7:6]; held until next hdr_valid.
- dt  out  6  data type, DI[5:0]; held.
- wc  out  16  word count {byte2, byte1}; held.
- ecc_err  out  1  header ECC mismatch; held with hdr fields.
- pix_valid  out  1  one-clock pulse per payload byte.
- pix_byte  out  8  payload byte; held between pulses.
- pkt_end  out  1  one-clock pulse after the last CRC byte.
- crc_err  out  1  CRC mismatch; valid with pkt_end, held.
- frame_start, frame_end, line_start, line_end  out  1 each  one-clock pulses for short DT 0x00/0x01/0x02/0x03 with ecc_err=0.
- trunc_err  out  1  one-clock pulse when hs_mode falls mid-packet.
- wc_err  out  1  one-clock pulse when a long-packet WC exceeds WC_MAX.

All outputs reset to 0.

## Operation
- A byte is **accepted** when `hs_mode & found_sot & byte_gate`.
- States:
  - IDLE: first accepted byte is stored as DI → HDR (hdr_cnt=1).
  - HDR: accepted bytes 1, 2, 3 are WC lsb, WC msb and ECC. On ECC:
    - Compute the 6-bit CSI-2 v1.x Hamming ECC over D[23:0]={WC msb, WC lsb, DI}, with D0=DI[0].
    - Compare it against {2'b00, ECC[5:0]}. A mismatch, or ECC[7:6]≠0, sets ecc_err.
    - Pulse hdr_valid.
    - Next state:
      - dt<0x10 (short packet): fire the sync pulse if applicable → WAIT_LP.
      - dt≥0x10 and wc>WC_MAX: wc_err → WAIT_LP.
      - dt≥0x10 and wc=0: → CRC.
      - otherwise: → PAYLOAD.
  - PAYLOAD:
    - Each accepted byte pulses pix_valid, feeds the CRC and decrements the 16-bit remaining count.
    - Leave PAYLOAD for CRC when the count reaches 0.
  - CRC:
    - Two accepted bytes, LS byte first.
    - After the second byte, compare the running CRC with the received CRC, set crc_err and pulse pkt_end → WAIT_LP.
  - WAIT_LP: ignore all bytes (EoT trailer) until hs_mode=0 → IDLE.
- CRC algorithm: CRC-16-CCITT, poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, LSB-first per byte, no final XOR.
- Long packets with ecc_err=1 are still parsed using the received WC; ECC correction is not performed.
- Payload bytes continue to flow when ecc_err=1; the downstream consumer decides whether to drop the packet.
- hs_mode=0 in HDR, PAYLOAD or CRC:
  - Pulse trunc_err and go to IDLE.
  - No pkt_end is issued.
  - Held fields keep their last values.
- hs_mode=0 in IDLE or WAIT_LP: go to IDLE with no error.
- One packet per HS burst. A second packet needs hs_mode to fall first.
- rst mid-operation: state returns to IDLE, the CRC register reloads 0xFFFF and all outputs clear asynchronously.

## Timing
- All outputs are registered.
- Latency is one clock after the accepting clock edge:
  - hdr_valid: the clock after the ECC byte is accepted.
  - pix_valid: the clock after each payload byte is accepted.
  - pkt_end/crc_err: the clock after the second CRC byte is accepted.
  - Sync pulses: coincident with hdr_valid.
- trunc_err: the clock after hs_mode is first sampled low in HDR, PAYLOAD or CRC.
- pix_valid is never asserted in two consecutive clocks, because it inherits the byte_gate spacing.
- hdr_valid precedes the first pix_valid by ≥4 clocks.
- No backpressure; the consumer must accept every pulse.

## Test plan
- Short packet FS: bytes 00 00 00 00 → hdr_valid with vc=0, dt=0x00, wc=0, ecc_err=0, and frame_start in the same clock. No pix_valid and no pkt_end.
- Short packet FS with corrupted ECC (00 00 00 01) → ecc_err=1 and frame_start stays 0.
- Long packet dt=0x2A, wc=24, model-computed ECC, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC bytes F0 00 → 24 pix_valid pulses with matching bytes, then pkt_end with crc_err=0. Same stimulus with CRC F1 00 → crc_err=1.
- Long packet with wc=0 → hdr_valid, then two CRC bytes FF FF → pkt_end with crc_err=0 and no pix_valid.
- Truncation: long packet with wc=100 and hs_mode dropped after 10 payload bytes → trunc_err pulses once, no pkt_end, and the next burst parses normally. Also cover wc=WC_MAX+1 → wc_err with no pix_valid.
- Assert rst during PAYLOAD → all outputs 0 the same clock. The next burst yields a correct hdr_valid, and the CRC result is unaffected by the aborted packet.
